// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_pkg
//  Description : Shared definitions for the memory bus arbiter. Holds the
//                bus size codes, the arbiter state encoding, the owner codes
//                and the load/store alignment check.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_bus_pkg;

    // Bus transfer size codes
    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam logic [1:0] SZ_DOUBLE = 2'b11;

    // Arbiter state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    // Owner codes; also the bit index of each requester in req/grant vectors
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    // True when the low address bits are a multiple of the transfer size.
    function automatic logic is_aligned(input logic [2:0] addr_lo,
                                        input logic [1:0] size);
        logic ok;
        ok = 1'b1;
        case (size)
            SZ_HALF:   ok = ~addr_lo[0];
            SZ_WORD:   ok = (addr_lo[1:0] == 2'b00);
            SZ_DOUBLE: ok = (addr_lo == 3'b000);
            default:   ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin picker. Produces a one-hot grant from
//                the request vector; on a tie the favoured port wins. The
//                pointer moves to the port that was not granted whenever
//                i_update is strobed with a non-zero grant.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_req[1:0]    - requests, bit OWN_IF / bit OWN_LS
//                i_update      - advance the pointer using the current grant
//                o_grant[1:0]  - one-hot grant (zero when no request)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
    import mem_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_grant
);

    // Index of the port that wins the next tie
    logic r_prio;
    logic [1:0] w_grant;

    always_comb begin
        w_grant = 2'b00;
        if (i_req == 2'b11) begin
            w_grant[r_prio] = 1'b1;
        end else begin
            // Zero or one request: the vector is already one-hot or empty
            w_grant = i_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= OWN_LS;
        end else if (i_update && (|w_grant)) begin
            // Favour LS next only when IF just won, and vice versa
            r_prio <= w_grant[OWN_IF];
        end
    end

    assign o_grant = w_grant;

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Shares one memory bus between instruction fetch (IF) and
//                load/store (LS). Round-robin grant, fixed-latency access of
//                WAIT_CYCLES cycles, one-cycle bus turnaround with a done
//                pulse to the owner. Misaligned LS requests are rejected
//                without touching the bus.
//  Ports       : clock, reset                  - clock, sync active-high reset
//                if_req/if_addr                - fetch request (32-bit read)
//                if_rdata/if_done              - fetch result / completion
//                ls_req/ls_we/ls_addr/ls_size/ls_wdata - load/store request
//                ls_rdata/ls_done/ls_err       - load result / completion
//                mem_address/mem_read/mem_write/mem_size - bus command
//                mem_wdata/mem_wdata_en        - bus write data and enable
//                mem_rdata                     - sampled bus read data
//                busy                          - arbiter not idle
//  Revision    : 1.0  initial release
// ============================================================================
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int WAIT_CYCLES = 2
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [1:0]        ls_size,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_done,
    output logic              ls_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        mem_size,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdata_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [3:0] c_cnt_init = 4'(WAIT_CYCLES - 1);

    logic [1:0]        r_state;
    logic              r_owner;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_mem_address;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [1:0]        r_mem_size;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_wdata_en;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata;
    logic              r_if_done;
    logic              r_ls_done;
    logic              r_ls_err;

    logic [1:0] w_req;
    logic [1:0] w_grant;
    logic       w_update;
    logic       w_ls_aligned;

    assign w_req        = {ls_req, if_req};
    // Requests are only arbitrated while idle, so the pointer only moves then
    assign w_update     = (r_state == ST_IDLE) && (|w_req);
    assign w_ls_aligned = is_aligned(ls_addr[2:0], ls_size);

    rr_arb2 u_rr_arb2 (
        .clk      (clock),
        .rst      (reset),
        .i_req    (w_req),
        .i_update (w_update),
        .o_grant  (w_grant)
    );

    // The mem_* output registers double as the request latch: they are loaded
    // on grant, held through ACCESS and cleared for the turnaround cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_owner        <= OWN_IF;
            r_cnt          <= 4'd0;
            r_mem_address  <= '0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_mem_size     <= 2'b00;
            r_mem_wdata    <= '0;
            r_mem_wdata_en <= 1'b0;
            r_if_rdata     <= '0;
            r_ls_rdata     <= '0;
            r_if_done      <= 1'b0;
            r_ls_done      <= 1'b0;
            r_ls_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant[OWN_IF]) begin
                        r_owner       <= OWN_IF;
                        r_mem_address <= if_addr;
                        r_mem_size    <= SZ_WORD;
                        r_mem_read    <= 1'b1;
                        r_cnt         <= c_cnt_init;
                        r_state       <= ST_ACCESS;
                    end else if (w_grant[OWN_LS]) begin
                        r_owner <= OWN_LS;
                        if (!w_ls_aligned) begin
                            // Rejected without a bus cycle; rdata untouched
                            r_ls_done <= 1'b1;
                            r_ls_err  <= 1'b1;
                            r_state   <= ST_RECOVER;
                        end else begin
                            r_mem_address  <= ls_addr;
                            r_mem_size     <= ls_size;
                            r_mem_read     <= ~ls_we;
                            r_mem_write    <= ls_we;
                            r_mem_wdata    <= ls_we ? ls_wdata : '0;
                            r_mem_wdata_en <= ls_we;
                            r_cnt          <= c_cnt_init;
                            r_state        <= ST_ACCESS;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        if (r_mem_read) begin
                            if (r_owner == OWN_LS) begin
                                r_ls_rdata <= mem_rdata;
                            end else begin
                                r_if_rdata <= mem_rdata;
                            end
                        end
                        r_mem_address  <= '0;
                        r_mem_read     <= 1'b0;
                        r_mem_write    <= 1'b0;
                        r_mem_size     <= 2'b00;
                        r_mem_wdata    <= '0;
                        r_mem_wdata_en <= 1'b0;
                        r_if_done      <= (r_owner == OWN_IF);
                        r_ls_done      <= (r_owner == OWN_LS);
                        r_state        <= ST_RECOVER;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                ST_RECOVER: begin
                    r_if_done <= 1'b0;
                    r_ls_done <= 1'b0;
                    r_ls_err  <= 1'b0;
                    r_state   <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_address  = r_mem_address;
    assign mem_read     = r_mem_read;
    assign mem_write    = r_mem_write;
    assign mem_size     = r_mem_size;
    assign mem_wdata    = r_mem_wdata;
    assign mem_wdata_en = r_mem_wdata_en;
    assign if_rdata     = r_if_rdata;
    assign if_done      = r_if_done;
    assign ls_rdata     = r_ls_rdata;
    assign ls_done      = r_ls_done;
    assign ls_err       = r_ls_err;
    assign busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire
